// File: rtl/song_sequencer.sv
// song_sequencer
// Shares the single buzzer note path between live key play and autoplay of
// stored songs. It also owns song selection (next/previous) and the song ROM
// address.
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   mode         0 = free play, 1 = autoplay
//   keys[6:0]    piano keys, bit0 = do ... bit6 = si
//   play_btn     start/stop autoplay (acts on the rising edge)
//   song_select  bit0 = next song, bit1 = previous song (act on rising edges)
//   rom_song     selected song index, to the ROM (always equals song_idx)
//   rom_addr     entry address, to the ROM (synchronous ROM, 1-cycle latency)
//   rom_data     [7:4] duration in beats (0 = end marker), [3:0] note (0 = rest)
//   note_out     note to the buzzer, 0 = silent
//   led_out      one-hot of the sounding note
//   playing      high while the autoplay FSM is not IDLE
//   song_idx     currently selected song
//
// GAP_CYCLES must be at least 1 and less than BEAT_CYCLES.
//
// state | meaning
// IDLE  | free play (mode=0) or silent; waits for a play_btn edge with mode=1
// FETCH | rom_addr presented to the ROM, silent
// WAIT  | rom_data valid: end marker -> IDLE, else latch note/duration
// PLAY  | latched note sounding for duration*BEAT_CYCLES - GAP_CYCLES cycles
// GAP   | articulation silence for GAP_CYCLES cycles, then the next entry

module song_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [6:0]        keys,
    input  logic              play_btn,
    input  logic [1:0]        song_select,
    output logic [1:0]        rom_song,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        note_out,
    output logic [6:0]        led_out,
    output logic              playing,
    output logic [1:0]        song_idx
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0]     BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [BW-1:0]     GAP_MARK  = BW'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              mode_m, mode_s;
    logic [6:0]        keys_m, keys_s;
    logic              pb_m, pb_s, pb_d;
    logic [1:0]        ss_m, ss_s, ss_d;

    logic [BW-1:0]     beat_cnt, beat_nxt;
    logic [3:0]        dur_cnt, dur_nxt;
    logic [3:0]        note_lat, nlat_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [1:0]        song_nxt;
    logic [3:0]        note_nxt;

    logic              pb_edge, next_edge, prev_edge, song_chg, abort;

    function automatic logic [3:0] key_note(input logic [6:0] k);
        logic [3:0] n;
        n = '0;
        // Walk from the top down so the lowest pressed key wins.
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [6:0] note_led(input logic [3:0] n);
        logic [6:0] l;
        l = '0;
        if (n >= 4'd1 && n <= 4'd7) l = 7'd1 << (n - 4'd1);
        return l;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_m <= 1'b0;
            mode_s <= 1'b0;
            keys_m <= '0;
            keys_s <= '0;
            pb_m   <= 1'b0;
            pb_s   <= 1'b0;
            pb_d   <= 1'b0;
            ss_m   <= '0;
            ss_s   <= '0;
            ss_d   <= '0;
        end else begin
            mode_m <= mode;
            mode_s <= mode_m;
            keys_m <= keys;
            keys_s <= keys_m;
            pb_m   <= play_btn;
            pb_s   <= pb_m;
            pb_d   <= pb_s;
            ss_m   <= song_select;
            ss_s   <= ss_m;
            ss_d   <= ss_s;
        end
    end

    assign pb_edge   = pb_s & ~pb_d;
    assign next_edge = ss_s[0] & ~ss_d[0];
    assign prev_edge = ss_s[1] & ~ss_d[1];
    // Next and previous in the same cycle cancel out.
    assign song_chg  = next_edge ^ prev_edge;

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        song_nxt  = song_idx;
        beat_nxt  = beat_cnt;
        dur_nxt   = dur_cnt;
        nlat_nxt  = note_lat;
        note_nxt  = 4'd0;
        abort     = 1'b0;

        if (song_chg) song_nxt = next_edge ? song_idx + 2'd1 : song_idx - 2'd1;

        // Song change, mode drop and play_btn all abort the same way; listing
        // them together keeps song change first in priority.
        if (state != IDLE && (song_chg || !mode_s || pb_edge)) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            abort     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!song_chg && mode_s && pb_edge) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end
                end
                FETCH: state_nxt = WAIT;
                WAIT: begin
                    if (rom_data[7:4] == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PLAY;
                        nlat_nxt  = rom_data[3:0];
                        dur_nxt   = rom_data[7:4];
                        beat_nxt  = BEAT_LAST;
                    end
                end
                PLAY: begin
                    // The last beat stops early at GAP_MARK; GAP then finishes
                    // that beat, so PLAY+GAP is exactly duration beats.
                    if (dur_cnt == 4'd1 && beat_cnt == GAP_MARK) begin
                        state_nxt = GAP;
                        beat_nxt  = beat_cnt - BW'(1);
                    end else if (beat_cnt == '0) begin
                        beat_nxt = BEAT_LAST;
                        dur_nxt  = dur_cnt - 4'd1;
                    end else begin
                        beat_nxt = beat_cnt - BW'(1);
                    end
                end
                GAP: begin
                    if (beat_cnt == '0) begin
                        if (rom_addr == ADDR_LAST) begin
                            state_nxt = IDLE;
                        end else begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = FETCH;
                        end
                    end else begin
                        beat_nxt = beat_cnt - BW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        case (state_nxt)
            IDLE:    note_nxt = (abort || mode_s) ? 4'd0 : key_note(keys_s);
            PLAY:    note_nxt = nlat_nxt;
            default: note_nxt = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            song_idx <= 2'd0;
            beat_cnt <= '0;
            dur_cnt  <= 4'd0;
            note_lat <= 4'd0;
            note_out <= 4'd0;
            led_out  <= 7'd0;
            playing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rom_addr <= addr_nxt;
            song_idx <= song_nxt;
            beat_cnt <= beat_nxt;
            dur_cnt  <= dur_nxt;
            note_lat <= nlat_nxt;
            note_out <= note_nxt;
            led_out  <= note_led(note_nxt);
            playing  <= (state_nxt != IDLE);
        end
    end

    assign rom_song = song_idx;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;
    localparam int B  = 10;
    localparam int G  = 2;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic [6:0]    keys = '0;
    logic          play_btn = 1'b0;
    logic [1:0]    song_select = '0;
    logic [1:0]    rom_song;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [3:0]    note_out;
    logic [6:0]    led_out;
    logic          playing;
    logic [1:0]    song_idx;

    logic [7:0] rom [4][256];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] note;
        logic       pl;
        int         addr;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_song][rom_addr];

    song_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .keys(keys), .play_btn(play_btn),
        .song_select(song_select), .rom_song(rom_song), .rom_addr(rom_addr),
        .rom_data(rom_data), .note_out(note_out), .led_out(led_out),
        .playing(playing), .song_idx(song_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: lowest pressed key number, 1-based.
    function automatic logic [3:0] model_note(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    function automatic logic [6:0] model_led(input logic [3:0] n);
        if (n == 0) return 7'd0;
        return 7'(1 << (n - 1));
    endfunction

    task automatic pulse_sel(input logic [1:0] v);
        song_select = v;
        step(3);
        song_select = 2'b00;
        step(3);
    endtask

    task automatic select_song(input logic [1:0] t);
        for (int i = 0; i < 4 && song_idx != t; i++) pulse_sel(2'b01);
        check("select_song", song_idx, t);
    endtask

    task automatic start_play();
        play_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (playing === 1'b1) break;
        end
        check("start_playing", playing, 1'b1);
        play_btn = 1'b0;
    endtask

    task automatic wait_note(input logic [3:0] n);
        for (int i = 0; i < 40; i++) begin
            if (note_out === n) break;
            step(1);
        end
        check("wait_note", note_out, n);
    endtask

    // Expected per-cycle timeline of a song, starting at the FETCH cycle of entry 0.
    task automatic build_song(input int s);
        int a;
        logic [3:0] d, n;
        q.delete();
        a = 0;
        forever begin
            d = rom[s][a][7:4];
            n = rom[s][a][3:0];
            repeat (2) q.push_back('{4'd0, 1'b1, a});
            if (d == 0) begin
                q.push_back('{4'd0, 1'b0, -1});
                break;
            end
            repeat (d * B - G) q.push_back('{n, 1'b1, a});
            repeat (G) q.push_back('{4'd0, 1'b1, a});
            if (a == 255) begin
                q.push_back('{4'd0, 1'b0, -1});
                break;
            end
            a++;
        end
    endtask

    task automatic run_song(input int s);
        build_song(s);
        start_play();
        foreach (q[i]) begin
            check("song_note", note_out, q[i].note);
            check("song_led", led_out, model_led(q[i].note));
            check("song_playing", playing, q[i].pl);
            if (q[i].addr >= 0) check("song_addr", rom_addr, q[i].addr);
            step(1);
        end
    endtask

    initial begin
        logic [6:0] k;
        int len;
        logic seen;

        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 256; a++) rom[s][a] = 8'h00;
        rom[0][0] = 8'h21;
        rom[0][1] = 8'h10;
        rom[0][2] = 8'h13;
        rom[0][3] = 8'h00;
        for (int s = 1; s <= 2; s++) begin
            len = $urandom_range(2, 5);
            for (int a = 0; a < len; a++)
                rom[s][a] = {4'($urandom_range(1, 3)), 4'($urandom_range(0, 7))};
        end
        for (int a = 0; a < 256; a++) rom[3][a] = {4'd1, 4'($urandom_range(0, 7))};

        // Reset state
        step(3);
        check("rst_note", note_out, 4'd0);
        check("rst_led", led_out, 7'd0);
        check("rst_playing", playing, 1'b0);
        check("rst_addr", rom_addr, 8'd0);
        check("rst_song", song_idx, 2'd0);
        check("rst_rom_song", rom_song, 2'd0);
        rst = 1'b0;
        step(2);

        // Free play latency
        keys = 7'b0010100;
        step(2);
        check("fp_latency_early", note_out, 4'd0);
        step(1);
        check("fp_note", note_out, 4'd3);
        check("fp_led", led_out, 7'b0000100);
        keys = 7'b0000000;
        step(2);
        check("fp_release_early", note_out, 4'd3);
        step(1);
        check("fp_release", note_out, 4'd0);
        check("fp_release_led", led_out, 7'd0);

        // Free play random
        for (int i = 0; i < 16; i++) begin
            k = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
            keys = k;
            step(3);
            check("fp_rand_note", note_out, model_note(k));
            check("fp_rand_led", led_out, model_led(model_note(k)));
        end

        // Autoplay idle is silent even with keys pressed
        mode = 1'b1;
        keys = 7'h7f;
        step(4);
        check("idle_mode1_silent", note_out, 4'd0);
        keys = 7'd0;

        // Song select
        pulse_sel(2'b10);
        check("prev_wrap", song_idx, 2'd3);
        check("rom_song_follow", rom_song, 2'd3);
        pulse_sel(2'b01);
        check("next_wrap", song_idx, 2'd0);
        pulse_sel(2'b01);
        pulse_sel(2'b01);
        check("two_next", song_idx, 2'd2);
        pulse_sel(2'b11);
        check("both_ignored", song_idx, 2'd2);
        pulse_sel(2'b10);
        pulse_sel(2'b10);
        check("back_to_0", song_idx, 2'd0);

        // Full songs
        run_song(0);
        select_song(2'd1);
        run_song(1);
        select_song(2'd2);
        run_song(2);

        // Address end without end marker
        select_song(2'd3);
        run_song(3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (playing !== 1'b0) seen = 1'b1;
            step(1);
        end
        check("addr_end_stays_idle", seen, 1'b0);

        // Abort by next-song edge during PLAY
        select_song(2'd0);
        start_play();
        wait_note(4'd1);
        song_select = 2'b01;
        step(2);
        check("abort_sel_early", playing, 1'b1);
        step(1);
        check("abort_sel_playing", playing, 1'b0);
        check("abort_sel_note", note_out, 4'd0);
        check("abort_sel_addr", rom_addr, 8'd0);
        check("abort_sel_song", song_idx, 2'd1);
        song_select = 2'b00;
        step(3);
        select_song(2'd0);

        // Mode drop mid-song
        start_play();
        wait_note(4'd1);
        mode = 1'b0;
        keys = 7'b1010000;
        step(2);
        check("mode_drop_early", playing, 1'b1);
        step(1);
        check("mode_drop_playing", playing, 1'b0);
        check("mode_drop_note", note_out, 4'd0);
        check("mode_drop_addr", rom_addr, 8'd0);
        step(1);
        check("mode_drop_freeplay", note_out, 4'd5);
        check("mode_drop_led", led_out, 7'b0010000);
        keys = 7'd0;
        mode = 1'b1;
        step(4);

        // Second play_btn edge mid-note
        start_play();
        wait_note(4'd1);
        step(2);
        play_btn = 1'b1;
        step(2);
        check("stop_early", playing, 1'b1);
        step(1);
        check("stop_playing", playing, 1'b0);
        check("stop_note", note_out, 4'd0);
        check("stop_addr", rom_addr, 8'd0);
        play_btn = 1'b0;
        step(4);

        // Asynchronous reset mid-PLAY
        select_song(2'd2);
        start_play();
        step(4);
        check("pre_rst_playing", playing, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_playing", playing, 1'b0);
        check("async_rst_note", note_out, 4'd0);
        check("async_rst_led", led_out, 7'd0);
        check("async_rst_addr", rom_addr, 8'd0);
        check("async_rst_song", song_idx, 2'd0);
        step(2);
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Arbitrates the single buzzer note path between live key play and autoplay of stored songs.
- Free-play mode: priority-encodes the seven keys into a note.
- Autoplay mode: steps through a song ROM of (duration, note) entries and times each note in beats, with a short articulation gap between notes.
- Sits between the key/switch inputs and the buzzer and LED blocks; also owns song selection (next/previous).

Parameters:
- BEAT_CYCLES, 25_000_000: clk cycles per beat (0.25 s at 100 MHz).
- GAP_CYCLES, 2_500_000: silent cycles at the end of every autoplay note. Must be < BEAT_CYCLES.
- ADDR_W, 8: per-song ROM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = free play, 1 = autoplay
- keys  in  7  piano keys, bit0 = do … bit6 = si
- play_btn  in  1  start/stop autoplay (level; rising edge acts)
- song_select  in  2  bit0 = next song, bit1 = previous song (rising edges act)
- rom_song  out  2  selected song index, to the ROM
- rom_addr  out  ADDR_W  entry address, to the ROM
- rom_data  in  8  [7:4] duration in beats (0 = end marker), [3:0] note (0 = rest, 1–7)
- note_out  out  4  note to the buzzer, 0 = silent
- led_out  out  7  one-hot of the sounding note, all 0 when silent
- playing  out  1  high while autoplay FSM is not IDLE
- song_idx  out  2  currently selected song

Behaviour:
- Reset (async, rst=1): all outputs 0. FSM = IDLE. song_idx = 0. All counters and synchronizers cleared.
- Input conditioning:
  - mode, keys, play_btn and song_select each pass through a 2-flop synchronizer.
  - Edge detectors act on the synchronized values.
- ROM interface: synchronous, 1-cycle latency. rom_data corresponds to the rom_addr presented in the previous cycle. rom_song always equals song_idx.
- Song select:
  - Next edge: song_idx+1 mod 4. Previous edge: song_idx−1 mod 4 (0 → 3).
  - Both edges in the same cycle: ignored.
  - Any accepted change while playing aborts to IDLE and resets rom_addr to 0.
- Free play (mode=0, FSM IDLE):
  - note_out = index of the lowest set key bit (keys[0] → 1 … keys[6] → 7); none pressed → 0.
  - Registered: 3 cycles from raw keys to note_out.
  - led_out = 1 << (note_out − 1), or 0 when note_out = 0.
- Autoplay FSM: IDLE → FETCH → WAIT → PLAY → GAP → FETCH …
  - IDLE: note_out follows free-play rule if mode=0, else 0. A play_btn edge with mode=1 → FETCH with rom_addr = 0.
  - FETCH (1 cycle): rom_addr driven; note_out = 0.
  - WAIT (1 cycle): sample rom_data.
    - duration = 0 → IDLE.
    - Otherwise latch note and duration → PLAY.
  - PLAY: note_out = latched note (rest → 0) for duration·BEAT_CYCLES − GAP_CYCLES cycles → GAP.
  - GAP: note_out = 0 for GAP_CYCLES cycles.
    - If rom_addr = 2^ADDR_W − 1 → IDLE (no wrap).
    - Else rom_addr+1 → FETCH.
  - Cycle count: exactly duration·BEAT_CYCLES cycles from PLAY entry to GAP exit. Each entry adds 2 cycles (FETCH/WAIT).
  - Counters: beat counter sized by $clog2(BEAT_CYCLES); duration counter 4 bits. Neither may overflow.
- Aborts (any non-IDLE state → IDLE next cycle, note_out = 0 that cycle, rom_addr = 0):
  - play_btn edge.
  - Synchronized mode falling to 0.
  - Accepted song change.
- Priority when events coincide: rst > song change > mode drop > play_btn > normal sequencing.
- play_btn edge with mode=0: ignored.
- playing = (FSM ≠ IDLE), registered with the state.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2, ROM model 1-cycle latency):
- Free play: keys=7'b0010100 held → note_out=3 and led_out=7'b0000100 on the 3rd cycle after the change; release → note_out=0 3 cycles later.
- Autoplay: song 0 ROM = {0x21, 0x10, 0x13, 0x00}, mode=1, play_btn pulse:
  - Entry 0x21: note 1 for 18 cycles, then 0 for 2.
  - Entry 0x10: rest, 0 for 10 cycles.
  - Entry 0x13: note 3 for 8, then 0 for 2.
  - End marker → playing falls.
  - 2 FETCH/WAIT cycles precede each entry.
- Song select: two next edges → song_idx=2; previous from 0 → 3; simultaneous next+previous → unchanged.
- Abort: next edge during PLAY → playing=0, note_out=0, rom_addr=0 within 3 cycles of the raw edge; song_idx advanced.
- Mode drop mid-song → FSM IDLE and free-play keys take effect. Second play_btn edge mid-note → stops.
- Address end: ROM with no end marker → after entry 255 FSM returns to IDLE without re-reading address 0. Reset asserted mid-PLAY → outputs 0 immediately (async).
